reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 64: number of entries; SHALL be a power of 2 and >= DISPATCH_W.
REQ-002 Parameter DISPATCH_W, default 4: dispatch slots per cycle.
REQ-003 Parameter WB_PORTS, default 4: forwarding-bus writeback ports.
REQ-004 Parameter COMMIT_W, default 2: maximum retirements per cycle; SHALL be <= DEPTH.
REQ-005 Parameter DATA_W, default 16: result value width; IDX_W = clog2(DEPTH); FWD_W = 1+IDX_W+DATA_W (23 at defaults).
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 flush  in  1  synchronous squash of all entries.
REQ-009 disp_valid  in  DISPATCH_W  per-slot dispatch request; slot 0 is oldest.
REQ-010 disp_pc  in  DISPATCH_W*16  instruction PC per slot.
REQ-011 disp_wr  in  DISPATCH_W  slot writes a register.
REQ-012 disp_dest  in  DISPATCH_W*3  destination register per slot.
REQ-013 disp_ready  out  1  high when free entries >= DISPATCH_W.
REQ-014 disp_idx  out  DISPATCH_W*IDX_W  tag allocated to each slot, (tail+i) mod DEPTH.
REQ-015 wb_bus  in  WB_PORTS*FWD_W  per port {valid, idx, value}, forwarding-bus format.
REQ-016 cm_valid  out  COMMIT_W  retiring-entry mask, contiguous from bit 0.
REQ-017 cm_wr / cm_dest / cm_value / cm_pc  out  COMMIT_W * (1 / 3 / DATA_W / 16)  retiring entry fields.
REQ-018 count  out  IDX_W+1  occupied entries; empty, full  out  1 each.

Function
REQ-019 Each entry holds: allocated bit, ready bit, pc, wr, dest, value.
REQ-020 Dispatch fires at an edge when disp_ready=1 and flush=0; only the leading contiguous run of set disp_valid bits is allocated; slots after the first clear bit are ignored.
REQ-021 An allocated entry gets allocated=1, ready=0 and pc/wr/dest stored; tail advances by n mod DEPTH.
REQ-022 disp_idx is combinational from current tail and valid in the same cycle as the request.
REQ-023 A writeback port with valid=1 addressing an allocated entry stores value and sets ready at the edge; writes to unallocated entries are dropped.
REQ-024 Two ports with the same idx in one cycle: the higher-numbered port's value is stored.
REQ-025 cm_valid[j] is combinational: 1 iff entries head..head+j are all allocated and ready, and j < count.
REQ-026 Entries flagged by cm_valid retire at the same edge: allocated cleared, head advances by popcount(cm_valid) mod DEPTH.
REQ-027 Latency: writeback at edge E -> cm_valid visible in the cycle after E -> retired at the following edge.
REQ-028 count_next = count + dispatched - retired; simultaneous dispatch and retire are legal. disp_ready uses current count only (same-cycle retirement not credited).
REQ-029 full = (count == DEPTH); empty = (count == 0); pointers wrap modulo DEPTH.
REQ-030 flush=1 has priority over everything: cm_valid forced 0 that cycle; at the edge head=tail=count=0, all allocated/ready bits cleared, same-cycle dispatch and writeback discarded.

Reset
REQ-031 reset asserted: head=tail=count=0, all allocated/ready bits cleared, immediately (no clock needed).
REQ-032 Outputs during and after reset: cm_valid=0, empty=1, full=0, disp_ready=1, count=0, disp_idx = {3,2,1,0} at defaults; payload fields need not be reset.
REQ-033 reset asserted mid-dispatch or mid-writeback discards that operation; first dispatch after release gets idx 0.

Verification
REQ-034 Reset, dispatch 4 (pc 0,2,4,6) -> disp_idx 0,1,2,3; count=4 next cycle; cm_valid=0.
REQ-035 Writeback idx2, then idx1, then idx0 on separate cycles -> cm_valid stays 0 until idx0 is ready, then 2'b11 (entries 0,1), then 2'b01 (entry 2); count goes 4->2->1.
REQ-036 16 dispatch groups with no writeback -> count=64, full=1, disp_ready=0; a 17th request leaves tail and count unchanged.
REQ-037 Wrap: head=tail=62, dispatch 4 -> disp_idx 62,63,0,1; write back all -> retire in order 62,63,0,1.
REQ-038 idx 5 written on port0 with 0x1111 and on port3 with 0x2222 in the same cycle -> cm_value for entry 5 = 0x2222.
REQ-039 count=10 with flush=1, a same-cycle dispatch and a same-cycle writeback -> cm_valid=0 that cycle; next cycle count=0, empty=1, next dispatch gets idx 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order retirement buffer. Up to DISPATCH_W instructions are
//   allocated per cycle at the tail. Results arrive out of order on the
//   forwarding bus, and up to COMMIT_W finished entries retire per cycle
//   from the head.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   flush             synchronous squash of every entry
//   disp_valid/pc/wr/dest  per-slot dispatch request, slot 0 oldest
//   disp_ready        at least DISPATCH_W entries are free
//   disp_idx          tag handed to each slot, (tail+i) mod DEPTH
//   wb_bus            per port {valid, idx, value}
//   cm_valid/wr/dest/value/pc  retiring entries, contiguous from lane 0
//   count, empty, full  occupancy status
module reorder_buffer #(
  parameter int DEPTH      = 64,
  parameter int DISPATCH_W = 4,
  parameter int WB_PORTS   = 4,
  parameter int COMMIT_W   = 2,
  parameter int DATA_W     = 16,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int FWD_W     = 1 + IDX_W + DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [DISPATCH_W-1:0]        disp_valid,
  input  logic [DISPATCH_W*16-1:0]     disp_pc,
  input  logic [DISPATCH_W-1:0]        disp_wr,
  input  logic [DISPATCH_W*3-1:0]      disp_dest,
  output logic                         disp_ready,
  output logic [DISPATCH_W*IDX_W-1:0]  disp_idx,
  input  logic [WB_PORTS*FWD_W-1:0]    wb_bus,
  output logic [COMMIT_W-1:0]          cm_valid,
  output logic [COMMIT_W-1:0]          cm_wr,
  output logic [COMMIT_W*3-1:0]        cm_dest,
  output logic [COMMIT_W*DATA_W-1:0]   cm_value,
  output logic [COMMIT_W*16-1:0]       cm_pc,
  output logic [IDX_W:0]               count,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = IDX_W + 1;

  logic [DEPTH-1:0]  allocated;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  allocNext;
  logic [DEPTH-1:0]  readyNext;
  logic [15:0]       pcMem    [DEPTH];
  logic              wrMem    [DEPTH];
  logic [2:0]        destMem  [DEPTH];
  logic [DATA_W-1:0] valueMem [DEPTH];
  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [CW-1:0]     dispCount;
  logic [CW-1:0]     retireCount;
  logic              dispFire;
  logic              wbValid [WB_PORTS];
  logic [IDX_W-1:0]  wbIdx   [WB_PORTS];
  logic [DATA_W-1:0] wbValue [WB_PORTS];

  // Occupancy flags. Dispatch only looks at the current count, so an entry
  // retiring this same cycle does not yet make room for a new group.
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign disp_ready = (count <= CW'(DEPTH - DISPATCH_W));
  assign dispFire   = disp_ready && !flush;

  // Split the forwarding bus into its per-port {valid, idx, value} fields.
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wbValid[p] = wb_bus[p*FWD_W + FWD_W - 1];
      wbIdx[p]   = wb_bus[p*FWD_W + DATA_W +: IDX_W];
      wbValue[p] = wb_bus[p*FWD_W +: DATA_W];
    end
  end

  // Tags are offered for every slot straight from the tail, but only the
  // leading unbroken run of valid slots is counted as dispatched; anything
  // after the first hole is ignored.
  always_comb begin
    logic run;
    run       = 1'b1;
    dispCount = '0;
    disp_idx  = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      run = run & disp_valid[i];
      if (run) dispCount = dispCount + CW'(1);
      disp_idx[i*IDX_W +: IDX_W] = tail + IDX_W'(i);
    end
  end

  // Retirement walks forward from the head and stops at the first entry that
  // is missing, not yet finished, or beyond the occupied range. Flush
  // suppresses retirement entirely for its cycle.
  always_comb begin
    logic             run;
    logic [IDX_W-1:0] ent;
    run         = 1'b1;
    ent         = head;
    cm_valid    = '0;
    cm_wr       = '0;
    cm_dest     = '0;
    cm_value    = '0;
    cm_pc       = '0;
    retireCount = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      ent = head + IDX_W'(j);
      run = run & allocated[ent] & ready[ent] & (CW'(j) < count);
      cm_valid[j]                = run & !flush;
      cm_wr[j]                   = wrMem[ent];
      cm_dest[j*3 +: 3]          = destMem[ent];
      cm_value[j*DATA_W +: DATA_W] = valueMem[ent];
      cm_pc[j*16 +: 16]          = pcMem[ent];
      if (cm_valid[j]) retireCount = retireCount + CW'(1);
    end
  end

  // Next allocated/ready vectors. Writebacks only land on entries that are
  // allocated right now, so a result aimed at a slot being dispatched this
  // same cycle is dropped, and the fresh allocation starts not-ready.
  always_comb begin
    allocNext = allocated;
    readyNext = ready;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wbValid[p] && allocated[wbIdx[p]]) readyNext[wbIdx[p]] = 1'b1;
    end
    for (int j = 0; j < COMMIT_W; j++) begin
      if (cm_valid[j]) begin
        allocNext[head + IDX_W'(j)] = 1'b0;
        readyNext[head + IDX_W'(j)] = 1'b0;
      end
    end
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (dispFire && (CW'(i) < dispCount)) begin
        allocNext[tail + IDX_W'(i)] = 1'b1;
        readyNext[tail + IDX_W'(i)] = 1'b0;
      end
    end
  end

  // Control state. Reset and flush both empty the buffer and rewind both
  // pointers to zero; otherwise pointers advance modulo DEPTH by natural
  // wrap of the IDX_W-bit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      allocated <= '0;
      ready     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else if (flush) begin
      allocated <= '0;
      ready     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      allocated <= allocNext;
      ready     <= readyNext;
      head      <= head + retireCount[IDX_W-1:0];
      tail      <= tail + (dispFire ? dispCount[IDX_W-1:0] : '0);
      count     <= count + (dispFire ? dispCount : '0) - retireCount;
    end
  end

  // Payload storage carries no reset; its contents only matter while the
  // matching allocated bit is set. Ports are visited in ascending order so
  // the highest-numbered port wins when two target the same entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (dispFire && (CW'(i) < dispCount)) begin
        pcMem[tail + IDX_W'(i)]   <= disp_pc[i*16 +: 16];
        wrMem[tail + IDX_W'(i)]   <= disp_wr[i];
        destMem[tail + IDX_W'(i)] <= disp_dest[i*3 +: 3];
      end
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wbValid[p] && allocated[wbIdx[p]] && !flush) valueMem[wbIdx[p]] <= wbValue[p];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Drives reorder_buffer with directed scenarios and randomized traffic and
//   compares every cycle against a queue-based model of in-order retirement.
module tb_reorder_buffer;

  localparam int DEPTH      = 64;
  localparam int DISPATCH_W = 4;
  localparam int WB_PORTS   = 4;
  localparam int COMMIT_W   = 2;
  localparam int DATA_W     = 16;
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int FWD_W      = 1 + IDX_W + DATA_W;
  localparam int BW         = WB_PORTS * FWD_W;

  logic                        clk;
  logic                        reset;
  logic                        flush;
  logic [DISPATCH_W-1:0]       disp_valid;
  logic [DISPATCH_W*16-1:0]    disp_pc;
  logic [DISPATCH_W-1:0]       disp_wr;
  logic [DISPATCH_W*3-1:0]     disp_dest;
  logic                        disp_ready;
  logic [DISPATCH_W*IDX_W-1:0] disp_idx;
  logic [BW-1:0]               wb_bus;
  logic [COMMIT_W-1:0]         cm_valid;
  logic [COMMIT_W-1:0]         cm_wr;
  logic [COMMIT_W*3-1:0]       cm_dest;
  logic [COMMIT_W*DATA_W-1:0]  cm_value;
  logic [COMMIT_W*16-1:0]      cm_pc;
  logic [IDX_W:0]              count;
  logic                        empty;
  logic                        full;

  int nVectors = 0;
  int nMiscompares = 0;

  // Reference model: a queue of tags in program order plus per-tag records.
  int                mQ[$];
  int                mTail;
  bit                mAlloc [DEPTH];
  bit                mReady [DEPTH];
  logic [15:0]       mPc    [DEPTH];
  bit                mWr    [DEPTH];
  logic [2:0]        mDest  [DEPTH];
  logic [DATA_W-1:0] mValue [DEPTH];

  logic [DISPATCH_W*IDX_W-1:0] idx3210;

  reorder_buffer #(
    .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .WB_PORTS(WB_PORTS),
    .COMMIT_W(COMMIT_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_wr(disp_wr),
    .disp_dest(disp_dest), .disp_ready(disp_ready), .disp_idx(disp_idx),
    .wb_bus(wb_bus), .cm_valid(cm_valid), .cm_wr(cm_wr), .cm_dest(cm_dest),
    .cm_value(cm_value), .cm_pc(cm_pc), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    mQ.delete();
    mTail = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mAlloc[i] = 1'b0;
      mReady[i] = 1'b0;
    end
  endfunction

  // Oldest entries retire while they are finished, at most COMMIT_W per cycle.
  function automatic logic [COMMIT_W-1:0] expCommit();
    logic [COMMIT_W-1:0] m;
    m = '0;
    if (flush) return m;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (j >= mQ.size()) break;
      if (!mReady[mQ[j]]) break;
      m[j] = 1'b1;
    end
    return m;
  endfunction

  function automatic int leadRun(input logic [DISPATCH_W-1:0] v);
    int n;
    n = 0;
    while (n < DISPATCH_W && v[n]) n++;
    return n;
  endfunction

  function automatic logic [BW-1:0] wbPut(input logic [BW-1:0] bus, input int p,
                                          input int idx, input logic [DATA_W-1:0] val);
    logic [BW-1:0] b;
    b = bus;
    b[p*FWD_W +: FWD_W] = {1'b1, IDX_W'(idx), val};
    return b;
  endfunction

  function automatic logic [BW-1:0] randomWb();
    logic [BW-1:0] b;
    int idx;
    b = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if ($urandom % 2 == 0) begin
        if (mQ.size() > 0 && ($urandom % 8) != 0) idx = mQ[$urandom_range(mQ.size() - 1)];
        else idx = int'($urandom % DEPTH);
        b = wbPut(b, p, idx, DATA_W'($urandom));
      end
    end
    return b;
  endfunction

  // Compare every DUT output against what the model says the buffer shows now.
  task automatic checkOutput();
    logic [COMMIT_W-1:0] m;
    int t;
    m = expCommit();
    check("count", 64'(count), 64'(mQ.size()));
    check("empty", 64'(empty), 64'(mQ.size() == 0));
    check("full", 64'(full), 64'(mQ.size() == DEPTH));
    check("disp_ready", 64'(disp_ready), 64'(mQ.size() <= DEPTH - DISPATCH_W));
    for (int i = 0; i < DISPATCH_W; i++)
      check("disp_idx", 64'(disp_idx[i*IDX_W +: IDX_W]), 64'((mTail + i) % DEPTH));
    check("cm_valid", 64'(cm_valid), 64'(m));
    for (int j = 0; j < COMMIT_W; j++) begin
      if (m[j]) begin
        t = mQ[j];
        check("cm_pc", 64'(cm_pc[j*16 +: 16]), 64'(mPc[t]));
        check("cm_wr", 64'(cm_wr[j]), 64'(mWr[t]));
        check("cm_dest", 64'(cm_dest[j*3 +: 3]), 64'(mDest[t]));
        check("cm_value", 64'(cm_value[j*DATA_W +: DATA_W]), 64'(mValue[t]));
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic updateModel();
    logic [COMMIT_W-1:0] m;
    int nd;
    int t;
    bit canDisp;
    logic [FWD_W-1:0] w;
    if (flush) begin
      modelReset();
      return;
    end
    m = expCommit();
    nd = leadRun(disp_valid);
    canDisp = (mQ.size() <= DEPTH - DISPATCH_W);
    for (int p = 0; p < WB_PORTS; p++) begin
      w = wb_bus[p*FWD_W +: FWD_W];
      t = int'(w[DATA_W +: IDX_W]);
      if (w[FWD_W-1] && mAlloc[t]) begin
        mReady[t] = 1'b1;
        mValue[t] = w[DATA_W-1:0];
      end
    end
    for (int j = 0; j < COMMIT_W; j++) begin
      if (m[j]) begin
        t = mQ.pop_front();
        mAlloc[t] = 1'b0;
        mReady[t] = 1'b0;
      end
    end
    if (canDisp) begin
      for (int i = 0; i < nd; i++) begin
        t = (mTail + i) % DEPTH;
        mQ.push_back(t);
        mAlloc[t] = 1'b1;
        mReady[t] = 1'b0;
        mPc[t]    = disp_pc[i*16 +: 16];
        mWr[t]    = disp_wr[i];
        mDest[t]  = disp_dest[i*3 +: 3];
      end
      mTail = (mTail + nd) % DEPTH;
    end
  endtask

  task automatic applyStimulus(input bit fl, input logic [DISPATCH_W-1:0] dv,
                               input logic [15:0] pcBase, input logic [BW-1:0] wb);
    flush      = fl;
    disp_valid = dv;
    for (int i = 0; i < DISPATCH_W; i++) begin
      disp_pc[i*16 +: 16] = pcBase + 16'(2 * i);
      disp_wr[i]          = 1'($urandom);
      disp_dest[i*3 +: 3] = 3'($urandom);
    end
    wb_bus = wb;
  endtask

  task automatic toNegedge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic toNextCycle();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic plainCycle();
    toNegedge();
    toNextCycle();
  endtask

  initial begin
    int budget;
    int n;
    logic [BW-1:0] wb;
    idx3210 = {6'd3, 6'd2, 6'd1, 6'd0};
    reset = 1'b1;
    flush = 1'b0;
    disp_valid = '0;
    disp_pc = '0;
    disp_wr = '0;
    disp_dest = '0;
    wb_bus = '0;
    modelReset();
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    check("rst_cm_valid", 64'(cm_valid), 64'd0);
    check("rst_disp_idx", 64'(disp_idx), 64'(idx3210));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Four-wide dispatch then out-of-order completion 2,1,0.
    applyStimulus(0, 4'hF, 16'h0000, '0);
    toNegedge();
    check("d4_disp_idx", 64'(disp_idx), 64'(idx3210));
    toNextCycle();
    applyStimulus(0, 4'h0, 16'h0, wbPut('0, 0, 2, 16'hA002));
    toNegedge();
    check("d4_count", 64'(count), 64'd4);
    check("d4_cm_valid", 64'(cm_valid), 64'd0);
    toNextCycle();
    applyStimulus(0, 4'h0, 16'h0, wbPut('0, 0, 1, 16'hA001));
    toNegedge();
    check("wb2_cm_valid", 64'(cm_valid), 64'd0);
    toNextCycle();
    applyStimulus(0, 4'h0, 16'h0, wbPut('0, 0, 0, 16'hA000));
    toNegedge();
    check("wb1_cm_valid", 64'(cm_valid), 64'd0);
    toNextCycle();
    applyStimulus(0, 4'h0, 16'h0, '0);
    toNegedge();
    check("ret01_cm_valid", 64'(cm_valid), 64'b11);
    check("ret01_cm_pc", 64'(cm_pc), 64'h0002_0000);
    check("ret01_cm_value", 64'(cm_value), 64'hA001_A000);
    toNextCycle();
    toNegedge();
    check("ret2_cm_valid", 64'(cm_valid), 64'b01);
    check("ret2_count", 64'(count), 64'd2);
    check("ret2_cm_pc", 64'(cm_pc[15:0]), 64'h0004);
    toNextCycle();
    applyStimulus(0, 4'h0, 16'h0, wbPut('0, 1, 3, 16'hA003));
    toNegedge();
    check("ret2_count_after", 64'(count), 64'd1);
    toNextCycle();
    applyStimulus(0, 4'h0, 16'h0, '0);
    plainCycle();

    // Fill to capacity, then one more request that must be refused.
    for (int g = 0; g < 16; g++) begin
      applyStimulus(0, 4'hF, 16'(g * 8), '0);
      plainCycle();
    end
    applyStimulus(0, 4'hF, 16'h0800, '0);
    toNegedge();
    check("full_count", 64'(count), 64'd64);
    check("full_flag", 64'(full), 64'd1);
    check("full_disp_ready", 64'(disp_ready), 64'd0);
    toNextCycle();
    toNegedge();
    check("full_hold_count", 64'(count), 64'd64);
    check("full_hold_idx", 64'(disp_idx), 64'({6'd7, 6'd6, 6'd5, 6'd4}));
    toNextCycle();
    applyStimulus(1, 4'h0, 16'h0, '0);
    plainCycle();

    // Walk the pointers round to 62 with an empty buffer.
    budget = 0;
    while ((mTail != 62 || mQ.size() != 0) && budget < 400) begin
      wb = '0;
      n = 0;
      foreach (mQ[k]) begin
        if (n < WB_PORTS && !mReady[mQ[k]]) begin
          wb = wbPut(wb, n, mQ[k], DATA_W'($urandom));
          n++;
        end
      end
      applyStimulus(0, (mTail != 62) ? 4'b0011 : 4'b0000, 16'(budget * 4), wb);
      plainCycle();
      budget++;
    end
    check("wrap_setup_in_budget", 64'(budget < 400), 64'd1);
    applyStimulus(0, 4'hF, 16'h0100, '0);
    toNegedge();
    check("wrap_disp_idx", 64'(disp_idx), 64'({6'd1, 6'd0, 6'd63, 6'd62}));
    toNextCycle();
    wb = wbPut('0, 0, 62, 16'hB062);
    wb = wbPut(wb, 1, 63, 16'hB063);
    wb = wbPut(wb, 2, 0, 16'hB000);
    wb = wbPut(wb, 3, 1, 16'hB001);
    applyStimulus(0, 4'h0, 16'h0, wb);
    plainCycle();
    applyStimulus(0, 4'h0, 16'h0, '0);
    toNegedge();
    check("wrap_ret_a_valid", 64'(cm_valid), 64'b11);
    check("wrap_ret_a_pc", 64'(cm_pc), 64'h0102_0100);
    toNextCycle();
    toNegedge();
    check("wrap_ret_b_valid", 64'(cm_valid), 64'b11);
    check("wrap_ret_b_pc", 64'(cm_pc), 64'h0106_0104);
    toNextCycle();

    // Same tag on port 0 and port 3: port 3 must win.
    applyStimulus(0, 4'hF, 16'h0200, '0);
    plainCycle();
    wb = wbPut('0, 0, 5, 16'h1111);
    wb = wbPut(wb, 1, 2, 16'hC002);
    wb = wbPut(wb, 2, 3, 16'hC003);
    wb = wbPut(wb, 3, 5, 16'h2222);
    applyStimulus(0, 4'h0, 16'h0, wb);
    plainCycle();
    applyStimulus(0, 4'h0, 16'h0, wbPut('0, 0, 4, 16'h4444));
    toNegedge();
    check("prio_first_valid", 64'(cm_valid), 64'b11);
    toNextCycle();
    applyStimulus(0, 4'h0, 16'h0, '0);
    toNegedge();
    check("prio_valid", 64'(cm_valid), 64'b11);
    check("prio_value", 64'(cm_value), 64'h2222_4444);
    toNextCycle();

    // Flush at count 10 with dispatch and writeback in the same cycle.
    applyStimulus(0, 4'hF, 16'h0300, '0);
    plainCycle();
    applyStimulus(0, 4'hF, 16'h0310, wbPut('0, 0, 7, 16'hD007));
    plainCycle();
    applyStimulus(0, 4'b0011, 16'h0320, wbPut('0, 0, 6, 16'hD006));
    plainCycle();
    applyStimulus(1, 4'hF, 16'h0330, wbPut('0, 2, 8, 16'hD008));
    toNegedge();
    check("flush_count_before", 64'(count), 64'd10);
    check("flush_cm_valid", 64'(cm_valid), 64'd0);
    toNextCycle();
    applyStimulus(0, 4'hF, 16'h0340, '0);
    toNegedge();
    check("flush_count_after", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_next_idx", 64'(disp_idx[IDX_W-1:0]), 64'd0);
    toNextCycle();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      applyStimulus(($urandom % 50) == 0, DISPATCH_W'($urandom), 16'($urandom), randomWb());
      plainCycle();
    end

    // Asynchronous reset in the middle of a dispatch/writeback cycle.
    applyStimulus(0, 4'hF, 16'h0400, randomWb());
    #2 reset = 1'b1;
    #1;
    check("areset_count", 64'(count), 64'd0);
    check("areset_empty", 64'(empty), 64'd1);
    check("areset_full", 64'(full), 64'd0);
    check("areset_cm_valid", 64'(cm_valid), 64'd0);
    check("areset_disp_ready", 64'(disp_ready), 64'd1);
    check("areset_disp_idx", 64'(disp_idx), 64'(idx3210));
    modelReset();
    @(posedge clk);
    #3 reset = 1'b0;
    toNegedge();
    check("post_reset_idx", 64'(disp_idx), 64'(idx3210));
    toNextCycle();
    applyStimulus(0, 4'h0, 16'h0, '0);
    toNegedge();
    check("post_reset_count", 64'(count), 64'd4);
    toNextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
